// File: rtl/mjpg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mjpg_pkg
// Brief    : JPEG marker constants and packer state encoding shared by the
//            MJPG stream packer and its word accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package mjpg_pkg;

    localparam logic [7:0] MK_PREFIX = 8'hFF;
    localparam logic [7:0] MK_SOI    = 8'hD8;
    localparam logic [7:0] MK_EOI    = 8'hD9;
    localparam logic [7:0] MK_RST0   = 8'hD0;
    localparam logic [7:0] MK_RST1   = 8'hD1;
    localparam logic [7:0] MK_RST2   = 8'hD2;
    localparam logic [7:0] MK_RST3   = 8'hD3;
    localparam logic [7:0] MK_RST4   = 8'hD4;
    localparam logic [7:0] MK_RST5   = 8'hD5;
    localparam logic [7:0] MK_RST6   = 8'hD6;
    localparam logic [7:0] MK_RST7   = 8'hD7;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_HUNT    = 2'd0;
    localparam logic [STATE_W-1:0] ST_FRAME   = 2'd1;
    localparam logic [STATE_W-1:0] ST_FLUSH   = 2'd2;
    localparam logic [STATE_W-1:0] ST_TRAILER = 2'd3;

    function automatic logic is_rst_marker(input logic [7:0] b);
        return (b == MK_RST0) || (b == MK_RST1) || (b == MK_RST2) || (b == MK_RST3) ||
               (b == MK_RST4) || (b == MK_RST5) || (b == MK_RST6) || (b == MK_RST7);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mjpg_word_acc.sv
`default_nettype none
// ============================================================================
// Module   : mjpg_word_acc
// Brief    : Packs bytes big-endian into 32-bit words and holds one output
//            word (data/keep/last) until the downstream accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module mjpg_word_acc
    import mjpg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load_soi,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    input  logic        i_push_last,
    input  logic        i_flush,
    input  logic        i_flush_last,
    input  logic        i_wr_word,
    input  logic [31:0] i_wr_data,
    input  logic        i_m_ready,
    output logic [1:0]  o_cnt,
    output logic        o_m_valid,
    output logic [31:0] o_m_data,
    output logic [3:0]  o_m_keep,
    output logic        o_m_last
);

    logic [23:0] r_acc;
    logic [1:0]  r_cnt;
    logic        w_word_full;
    logic [31:0] w_part_data;
    logic [3:0]  w_part_keep;

    assign o_cnt       = r_cnt;
    assign w_word_full = i_push && (r_cnt == 2'd3);

    // Oldest byte sits highest; partial words are padded with zero low bytes.
    always_comb begin
        w_part_data = 32'h0;
        w_part_keep = 4'b0000;
        case (r_cnt)
            2'd1: begin w_part_data = {r_acc[7:0], 24'h0};  w_part_keep = 4'b1000; end
            2'd2: begin w_part_data = {r_acc[15:0], 16'h0}; w_part_keep = 4'b1100; end
            2'd3: begin w_part_data = {r_acc, 8'h0};        w_part_keep = 4'b1110; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 24'h0;
            r_cnt <= 2'd0;
        end else if (i_load_soi) begin
            r_acc <= {8'h00, MK_PREFIX, MK_SOI};
            r_cnt <= 2'd2;
        end else if (i_push) begin
            r_acc <= {r_acc[15:0], i_byte};
            r_cnt <= r_cnt + 2'd1;
        end else if (i_flush) begin
            r_cnt <= 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_m_valid <= 1'b0;
            o_m_data  <= 32'h0;
            o_m_keep  <= 4'b0000;
            o_m_last  <= 1'b0;
        end else if (w_word_full) begin
            o_m_valid <= 1'b1;
            o_m_data  <= {r_acc, i_byte};
            o_m_keep  <= 4'b1111;
            o_m_last  <= i_push_last;
        end else if (i_flush) begin
            o_m_valid <= 1'b1;
            o_m_data  <= w_part_data;
            o_m_keep  <= w_part_keep;
            o_m_last  <= i_flush_last;
        end else if (i_wr_word) begin
            o_m_valid <= 1'b1;
            o_m_data  <= i_wr_data;
            o_m_keep  <= 4'b1111;
            o_m_last  <= 1'b1;
        end else if (i_m_ready) begin
            o_m_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mjpg_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : mjpg_stream_packer
// Brief    : Pops MJPG encoder bytes, frames SOI..EOI and streams them as
//            big-endian 32-bit words with per-frame length/error reporting.
// Config   : MJPG_LEN_TRAILER_EN appends a length trailer word to each frame.
// Revision : 1.0 - initial release
// ============================================================================
module mjpg_stream_packer
    import mjpg_pkg::*;
#(
    parameter int LEN_W     = 24,
    parameter int MAX_BYTES = 1 << 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    output logic             dequeue,
    input  logic [7:0]       jpeg,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic [3:0]       m_keep,
    output logic             m_last,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_err
);

`ifdef MJPG_LEN_TRAILER_EN
    localparam logic c_trailer = 1'b1;
`else
    localparam logic c_trailer = 1'b0;
`endif

    generate
        if (((MAX_BYTES >> LEN_W) != 0) || (MAX_BYTES < 3)) begin : g_bad_max_bytes
            $error("MAX_BYTES must lie in [3, 2**LEN_W)");
        end
        if ((LEN_W < 2) || (LEN_W > 31)) begin : g_bad_len_w
            $error("LEN_W must lie in [2, 31]");
        end
    endgenerate

    logic [STATE_W-1:0] r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_len, w_len_inc, r_frame_len;
    logic               r_prev_ff, r_abort, r_frame_done, r_frame_err;
    logic               w_deq, w_accept, w_out_free, w_is_eoi, w_term;
    logic               w_load_soi, w_push, w_push_last, w_flush, w_flush_last;
    logic               w_wr_word, w_finish;
    logic [1:0]         w_acc_cnt;
    logic [31:0]        w_trailer;

    assign w_out_free = !m_valid || m_ready;
    assign w_deq      = (r_state == ST_HUNT) ||
                        ((r_state == ST_FRAME) && (w_out_free || (w_acc_cnt != 2'd3)));
    assign dequeue    = ready && w_deq && !rst;
    assign w_accept   = dequeue;
    assign w_len_inc  = r_len + 1'b1;
    // Stuffed FF 00 and restart markers are payload; only FF D9 closes a frame.
    assign w_is_eoi   = r_prev_ff && (jpeg == MK_EOI) && !is_rst_marker(jpeg);
    assign w_term     = w_is_eoi || (w_len_inc == LEN_W'(MAX_BYTES));
    assign w_trailer  = 32'(r_len) | {r_abort, 31'd0};

    assign frame_done = r_frame_done;
    assign frame_len  = r_frame_len;
    assign frame_err  = r_frame_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_load_soi   = 1'b0;
        w_push       = 1'b0;
        w_push_last  = 1'b0;
        w_flush      = 1'b0;
        w_flush_last = 1'b0;
        w_wr_word    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_accept && r_prev_ff && (jpeg == MK_SOI)) begin
                    w_load_soi  = 1'b1;
                    w_state_nxt = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (w_accept) begin
                    w_push      = 1'b1;
                    w_push_last = w_term && !c_trailer;
                    if (w_term) w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_acc_cnt != 2'd0) begin
                    if (w_out_free) begin
                        w_flush      = 1'b1;
                        w_flush_last = !c_trailer;
                        if (c_trailer) w_state_nxt = ST_TRAILER;
                    end
                end else if (c_trailer) begin
                    w_state_nxt = ST_TRAILER;
                end else if (m_valid && m_ready && m_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_TRAILER: begin
                if (m_valid && m_last) begin
                    if (m_ready) begin
                        w_finish    = 1'b1;
                        w_state_nxt = ST_HUNT;
                    end
                end else if (w_out_free) begin
                    w_wr_word = 1'b1;
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_len        <= '0;
            r_prev_ff    <= 1'b0;
            r_abort      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_len  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_finish && !r_abort;
            r_frame_err  <= w_finish && r_abort;
            if (w_accept) r_prev_ff <= (jpeg == MK_PREFIX);
            if (w_load_soi) begin
                r_len   <= LEN_W'(2);
                r_abort <= 1'b0;
            end else if (w_push) begin
                r_len <= w_len_inc;
                if (w_term) r_abort <= !w_is_eoi;
            end
            if (w_finish && !r_abort) r_frame_len <= r_len;
        end
    end

    mjpg_word_acc u_word_acc (
        .clk          (clk),
        .rst          (rst),
        .i_load_soi   (w_load_soi),
        .i_push       (w_push),
        .i_byte       (jpeg),
        .i_push_last  (w_push_last),
        .i_flush      (w_flush),
        .i_flush_last (w_flush_last),
        .i_wr_word    (w_wr_word),
        .i_wr_data    (w_trailer),
        .i_m_ready    (m_ready),
        .o_cnt        (w_acc_cnt),
        .o_m_valid    (m_valid),
        .o_m_data     (m_data),
        .o_m_keep     (m_keep),
        .o_m_last     (m_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_mjpg_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mjpg_stream_packer
// Brief    : Directed self-checking bench for mjpg_stream_packer (MAX_BYTES=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mjpg_stream_packer;

    localparam int LEN_W     = 24;
    localparam int MAX_BYTES = 16;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             ready   = 1'b0;
    logic [7:0]       jpeg    = 8'h00;
    logic             m_ready = 1'b1;
    logic             dequeue;
    logic             m_valid;
    logic [31:0]      m_data;
    logic [3:0]       m_keep;
    logic             m_last;
    logic             frame_done;
    logic [LEN_W-1:0] frame_len;
    logic             frame_err;

    mjpg_stream_packer #(.LEN_W(LEN_W), .MAX_BYTES(MAX_BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .dequeue    (dequeue),
        .jpeg       (jpeg),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    logic [7:0]  src_q[$];
    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];
    logic        do_pop = 1'b0;
    int          n_done = 0, n_err = 0, n_cmp = 0, n_bad = 0;
    int          done0 = 0, err0 = 0;
    logic [LEN_W-1:0] prev_len = '0, exp_len = '0;
    logic        exp_abort = 1'b0;

    // Observe on the falling edge; the DUT acts on the following rising edge.
    always @(negedge clk) begin
        do_pop = ready && dequeue;
        if (!rst && m_valid && m_ready) got_q.push_back({m_last, m_keep, m_data});
        if (frame_done) n_done = n_done + 1;
        if (frame_err)  n_err  = n_err + 1;
    end

    // Show-ahead byte source.
    always @(posedge clk) begin
        #1;
        if (do_pop && (src_q.size() != 0)) void'(src_q.pop_front());
        ready = (src_q.size() != 0);
        jpeg  = ready ? src_q[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [8*24-1:0] bytes, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic start_frame();
        got_q.delete();
        exp_q.delete();
        done0 = n_done;
        err0  = n_err;
    endtask

    task automatic expect_word(input logic last, input logic [3:0] keep, input logic [31:0] data);
        exp_q.push_back({last, keep, data});
    endtask

    task automatic expect_end(input logic [LEN_W-1:0] len, input logic abort);
        exp_len   = len;
        exp_abort = abort;
`ifdef MJPG_LEN_TRAILER_EN
        exp_q[exp_q.size()-1][36] = 1'b0;
        exp_q.push_back({1'b1, 4'hF, abort, 31'(len)});
`endif
    endtask

    task automatic wait_check(input string tag, input bit toggle);
        for (int c = 0; c < 400; c++) begin
            if ((got_q.size() >= exp_q.size()) && (src_q.size() == 0)) break;
            if (toggle) m_ready = c[0];
            tick(1);
        end
        m_ready = 1'b1;
        tick(4);
        check({tag, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s.w%0d", tag, i),
                  (i < got_q.size()) ? 64'(got_q[i]) : '1, 64'(exp_q[i]));
        check({tag, ".done"}, 64'(n_done - done0), exp_abort ? 64'd0 : 64'd1);
        check({tag, ".err"},  64'(n_err - err0),   exp_abort ? 64'd1 : 64'd0);
        if (!exp_abort) prev_len = exp_len;
        check({tag, ".len"}, 64'(frame_len), 64'(prev_len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a byte waiting so dequeue must be held low.
        src_q.push_back(8'h55);
        tick(3);
        check("rst.dequeue", 64'(dequeue), 64'd0);
        check("rst.m_valid", 64'(m_valid), 64'd0);
        check("rst.m_data", 64'(m_data), 64'd0);
        check("rst.m_keep", 64'(m_keep), 64'd0);
        check("rst.m_last", 64'(m_last), 64'd0);
        check("rst.frame_done", 64'(frame_done), 64'd0);
        check("rst.frame_len", 64'(frame_len), 64'd0);
        check("rst.frame_err", 64'(frame_err), 64'd0);
        rst = 1'b0;
        tick(3);
        check("hunt.drain", 64'(src_q.size()), 64'd0);

        // Minimal frame.
        start_frame();
        send(32'hFFD8FFD9, 4);
        expect_word(1'b1, 4'hF, 32'hFFD8FFD9);
        expect_end(4, 1'b0);
        wait_check("t1", 1'b0);

        // Garbage before SOI, FF FF D8 still detected.
        start_frame();
        send(64'h1234FFFFD8ABFFD9, 8);
        expect_word(1'b0, 4'hF, 32'hFFD8ABFF);
        expect_word(1'b1, 4'h8, 32'hD9000000);
        expect_end(5, 1'b0);
        wait_check("t2", 1'b0);

        // Stuffing and restart markers are payload.
        start_frame();
        send(88'hFFD8ABFF00CDFFD3EFFFD9, 11);
        expect_word(1'b0, 4'hF, 32'hFFD8ABFF);
        expect_word(1'b0, 4'hF, 32'h00CDFFD3);
        expect_word(1'b1, 4'hE, 32'hEFFFD900);
        expect_end(11, 1'b0);
        wait_check("t3", 1'b0);

        // Backpressure: first word held, accumulator fills to 3, then stalls.
        start_frame();
        m_ready = 1'b0;
        send(96'hFFD80102030405060708FFD9, 12);
        tick(12);
        check("t4.stall_src", 64'(src_q.size()), 64'd5);
        check("t4.stall_deq", 64'(dequeue), 64'd0);
        check("t4.stall_valid", 64'(m_valid), 64'd1);
        check("t4.stall_data", 64'(m_data), 64'hFFD80102);
        check("t4.stall_keep", 64'(m_keep), 64'hF);
        expect_word(1'b0, 4'hF, 32'hFFD80102);
        expect_word(1'b0, 4'hF, 32'h03040506);
        expect_word(1'b1, 4'hF, 32'h0708FFD9);
        expect_end(12, 1'b0);
        wait_check("t4", 1'b1);

        // EOI preceded by FF FF; partial two-byte tail.
        start_frame();
        send(48'hFFD801FFFFD9, 6);
        expect_word(1'b0, 4'hF, 32'hFFD801FF);
        expect_word(1'b1, 4'hC, 32'hFFD90000);
        expect_end(6, 1'b0);
        wait_check("t7", 1'b0);

        // EOI landing exactly on MAX_BYTES, full 1 byte/clk throughput.
        start_frame();
        send(128'hFFD800010203040506070809_0A0BFFD9, 16);
        tick(17);
        check("t8.rate", 64'(src_q.size()), 64'd0);
        expect_word(1'b0, 4'hF, 32'hFFD80001);
        expect_word(1'b0, 4'hF, 32'h02030405);
        expect_word(1'b0, 4'hF, 32'h06070809);
        expect_word(1'b1, 4'hF, 32'h0A0BFFD9);
        expect_end(16, 1'b0);
        wait_check("t8", 1'b0);

        // Runaway frame aborted at MAX_BYTES; tail bytes dropped in hunt.
        start_frame();
        send(160'hFFD810111213141516171819_1A1B1C1D1E1F2021, 20);
        expect_word(1'b0, 4'hF, 32'hFFD81011);
        expect_word(1'b0, 4'hF, 32'h12131415);
        expect_word(1'b0, 4'hF, 32'h16171819);
        expect_word(1'b1, 4'hF, 32'h1A1B1C1D);
        expect_end(16, 1'b1);
        wait_check("t5", 1'b0);

        start_frame();
        send(32'hFFD8FFD9, 4);
        expect_word(1'b1, 4'hF, 32'hFFD8FFD9);
        expect_end(4, 1'b0);
        wait_check("t5b", 1'b0);

        // Reset mid-frame discards the partial frame.
        m_ready = 1'b0;
        send(56'hFFD8AABBCCDDEE, 7);
        tick(12);
        check("t6.pre_valid", 64'(m_valid), 64'd1);
        rst = 1'b1;
        tick(2);
        check("t6.m_valid", 64'(m_valid), 64'd0);
        check("t6.m_data", 64'(m_data), 64'd0);
        check("t6.m_keep", 64'(m_keep), 64'd0);
        check("t6.m_last", 64'(m_last), 64'd0);
        check("t6.frame_len", 64'(frame_len), 64'd0);
        prev_len = '0;
        rst = 1'b0;
        m_ready = 1'b1;
        start_frame();
        send(56'hFFD911FFD8FFD9, 7);
        expect_word(1'b1, 4'hF, 32'hFFD8FFD9);
        expect_end(4, 1'b0);
        wait_check("t6b", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
